// File: rtl/tdm_mux8_pkg.sv
// Shared definitions for the eight-channel TDM serializer.
//   NUM_CH      : number of multiplexed channels
//   SEL_W       : width of the channel select sent downstream
//   HOLD_W      : width of the per-slot hold counter (SLOT_CYCLES up to 16)
//   tdm_state_t : serializer FSM states
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_mux8_if.sv
// Frame input handshake and serialized slot output of tdm_mux8.
//   in_valid/in_ready : frame handshake; a frame (in_data, in_mask) is taken
//                       at a rising edge where both are 1. in_valid may not
//                       depend on in_ready; the source holds its frame until
//                       taken, and nothing is captured while in_ready is 0.
//   d_out/s_out       : serialized bit and its channel number
//   d_valid           : d_out/s_out carry a live slot
//   frame_start/done  : single-cycle frame boundary pulses
// Modports: slave = the serializer, master = the frame source / line sink.
interface tdm_if;
  import tdm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [NUM_CH-1:0] in_data;
  logic [NUM_CH-1:0] in_mask;
  logic              d_out;
  logic [SEL_W-1:0]  s_out;
  logic              d_valid;
  logic              frame_start;
  logic              frame_done;

  modport slave (
    input  in_valid, in_data, in_mask,
    output in_ready, d_out, s_out, d_valid, frame_start, frame_done
  );

  modport master (
    output in_valid, in_data, in_mask,
    input  in_ready, d_out, s_out, d_valid, frame_start, frame_done
  );

endinterface

// File: rtl/tdm_mux8_next_ch_enc.sv
// Priority encoder: finds the lowest set mask bit strictly above a start
// index. start is one bit wider than a channel number and read as signed,
// so start = -1 (all ones) searches the whole mask.
//   mask  : channel enables
//   start : signed start index (-1..NUM_CH-1)
//   ch    : lowest set channel above start (0 when none)
//   none  : no set channel above start
module next_ch_enc
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W:0]    start,
  output logic [SEL_W-1:0]  ch,
  output logic              none
);

  // Scan downward so the last hit written is the lowest qualifying bit.
  always_comb begin
    ch   = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'($signed(start)))) begin
        ch   = SEL_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_mux8.sv
// Eight-channel time-division multiplexer / serializer. Takes a data word
// plus channel-enable mask and emits every enabled channel bit, lowest
// channel first, each held for SLOT_CYCLES cycles with its channel number.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : tdm_if.slave (frame handshake + serialized slot outputs)
//   state_dbg  : current FSM state
// All bus outputs are registered except in_ready, which is decoded from
// state and the last-slot condition (no path from in_valid).
module tdm_mux8
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_if.slave       bus,
  output tdm_state_t state_dbg
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SLOT_CYCLES - 1);

  tdm_state_t        state, state_n;
  logic [NUM_CH-1:0] data_r, data_n;
  logic [NUM_CH-1:0] mask_r, mask_n;
  logic [SEL_W-1:0]  ch_r, ch_n;
  logic [HOLD_W-1:0] hold_r, hold_n;

  logic              d_out_r, d_valid_r, fs_r, fd_r;
  logic [SEL_W-1:0]  s_out_r;
  logic              d_out_n, d_valid_n, fs_n, fd_n;
  logic [SEL_W-1:0]  s_out_n;

  logic              slot_end, last_slot, ready, accept, load;
  logic              new_frame, empty_done, live_n;
  logic [SEL_W-1:0]  first_ch, nxt_ch;
  logic              first_none, nxt_none;

  // First channel of an incoming frame.
  next_ch_enc u_first (
    .mask  (bus.in_mask),
    .start ({(SEL_W + 1){1'b1}}),
    .ch    (first_ch),
    .none  (first_none)
  );

  // Channel following the current one in the captured mask.
  next_ch_enc u_next (
    .mask  (mask_r),
    .start ({1'b0, ch_r}),
    .ch    (nxt_ch),
    .none  (nxt_none)
  );

  assign slot_end  = (state == SEND) && (hold_r == HOLD_MAX);
  assign last_slot = slot_end && nxt_none;
  // Held low during reset so no frame looks accepted while rst_n is low.
  assign ready     = rst_n && ((state == IDLE) || last_slot);
  assign accept    = bus.in_valid && ready;

  always_comb begin
    state_n    = state;
    data_n     = data_r;
    mask_n     = mask_r;
    ch_n       = ch_r;
    hold_n     = hold_r;
    load       = 1'b0;
    new_frame  = 1'b0;
    empty_done = 1'b0;

    case (state)
      IDLE: load = accept;
      SEND: begin
        if (!slot_end) begin
          hold_n = hold_r + 1'b1;
        end else if (!nxt_none) begin
          ch_n   = nxt_ch;
          hold_n = '0;
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      data_n = bus.in_data;
      mask_n = bus.in_mask;
      hold_n = '0;
      if (first_none) begin
        // Empty frame: nothing to send, just report completion.
        state_n    = IDLE;
        empty_done = 1'b1;
      end else begin
        state_n   = SEND;
        ch_n      = first_ch;
        new_frame = 1'b1;
      end
    end

    // Output registers are loaded with what the next cycle must show.
    // The next slot is the frame's last one when it is at terminal hold
    // and no enable bit sits above its channel.
    live_n    = (state_n == SEND);
    d_valid_n = live_n;
    d_out_n   = live_n && data_n[ch_n];
    s_out_n   = live_n ? ch_n : '0;
    fs_n      = new_frame;
    fd_n      = empty_done ||
                (live_n && (hold_n == HOLD_MAX) &&
                 ((mask_n >> ch_n) == NUM_CH'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_r    <= '0;
      mask_r    <= '0;
      ch_r      <= '0;
      hold_r    <= '0;
      d_valid_r <= 1'b0;
      d_out_r   <= 1'b0;
      s_out_r   <= '0;
      fs_r      <= 1'b0;
      fd_r      <= 1'b0;
    end else begin
      state     <= state_n;
      data_r    <= data_n;
      mask_r    <= mask_n;
      ch_r      <= ch_n;
      hold_r    <= hold_n;
      d_valid_r <= d_valid_n;
      d_out_r   <= d_out_n;
      s_out_r   <= s_out_n;
      fs_r      <= fs_n;
      fd_r      <= fd_n;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.d_valid     = d_valid_r;
  assign bus.d_out       = d_out_r;
  assign bus.s_out       = s_out_r;
  assign bus.frame_start = fs_r;
  assign bus.frame_done  = fd_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_tdm_mux8.sv
// Testbench for tdm_mux8: two instances (SLOT_CYCLES = 1 and 3) fed by
// independent frame streams and checked every cycle against a slot-list
// reference model.
module tb_tdm_mux8;
  import tdm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  tdm_if bus_a ();
  tdm_if bus_b ();
  tdm_state_t st_a, st_b;

  logic       iv [2];
  logic [7:0] id [2];
  logic [7:0] im [2];

  assign bus_a.in_valid = iv[0];
  assign bus_a.in_data  = id[0];
  assign bus_a.in_mask  = im[0];
  assign bus_b.in_valid = iv[1];
  assign bus_b.in_data  = id[1];
  assign bus_b.in_mask  = im[1];

  tdm_mux8 #(.SLOT_CYCLES(1)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .state_dbg (st_a)
  );

  tdm_mux8 #(.SLOT_CYCLES(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .state_dbg (st_b)
  );

  // ---------------- model / scoreboard ----------------
  // Expected line content per cycle: {d_valid, d_out, s_out[2:0], frame_start, frame_done}.
  logic [6:0]  exp_q  [2][$];
  // Frames waiting to be offered: {data, mask}.
  logic [15:0] pend_q [2][$];
  int          slot_cycles [2] = '{1, 3};
  int          errors = 0;
  int          checks = 0;
  bit          gaps   = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A frame is the list of its slots: each enabled channel, ascending,
  // repeated SLOT_CYCLES times. An empty mask yields one done-only cycle.
  task automatic push_frame(input int u, input logic [7:0] data, input logic [7:0] mask);
    bit first;
    bit last;
    first = 1'b1;
    if (mask == 8'h00) begin
      exp_q[u].push_back(7'b000_0001);
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (mask[c]) begin
          last = ((32'(mask) >> (c + 1)) == 0);
          for (int k = 0; k < slot_cycles[u]; k++)
            exp_q[u].push_back({1'b1, data[c], 3'(c),
                                first && (k == 0),
                                last && (k == slot_cycles[u] - 1)});
          first = 1'b0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    for (int u = 0; u < 2; u++) begin
      iv[u] = (pend_q[u].size() > 0) && !(gaps && ($urandom_range(0, 3) == 0));
      if (iv[u]) begin
        id[u] = pend_q[u][0][15:8];
        im[u] = pend_q[u][0][7:0];
      end else begin
        id[u] = 8'($urandom);
        im[u] = 8'($urandom);
      end
    end
  endtask

  task automatic enq(input logic [7:0] data, input logic [7:0] mask);
    pend_q[0].push_back({data, mask});
    pend_q[1].push_back({data, mask});
    drive_inputs();
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    bit         ready_pre;
    logic [6:0] obs;
    logic [6:0] exp;
    logic       obs_rdy;
    tdm_state_t obs_st;
    tdm_state_t exp_st;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      ready_pre = rst_n && (exp_q[u].size() <= 1);
      if (!rst_n) begin
        exp_q[u].delete();
      end else begin
        if (exp_q[u].size() > 0) void'(exp_q[u].pop_front());
        if (iv[u] && ready_pre) begin
          push_frame(u, id[u], im[u]);
          void'(pend_q[u].pop_front());
        end
      end
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin
        obs     = {bus_a.d_valid, bus_a.d_out, bus_a.s_out, bus_a.frame_start, bus_a.frame_done};
        obs_rdy = bus_a.in_ready;
        obs_st  = st_a;
      end else begin
        obs     = {bus_b.d_valid, bus_b.d_out, bus_b.s_out, bus_b.frame_start, bus_b.frame_done};
        obs_rdy = bus_b.in_ready;
        obs_st  = st_b;
      end
      exp    = (exp_q[u].size() > 0) ? exp_q[u][0] : 7'd0;
      exp_st = (exp_q[u].size() > 0 && exp_q[u][0][6]) ? SEND : IDLE;
      check(u == 0 ? "line_s1" : "line_s3", {1'b0, obs}, {1'b0, exp});
      check(u == 0 ? "ready_s1" : "ready_s3", {7'd0, obs_rdy},
            {7'd0, rst_n && (exp_q[u].size() <= 1)});
      check(u == 0 ? "state_s1" : "state_s3", {7'd0, obs_st}, {7'd0, exp_st});
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int  n;
    bit  busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      step();
      n++;
      busy = (pend_q[0].size() + pend_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0;
    end
    checks++;
    assert (!busy)
    else begin
      errors++;
      $error("FAIL drain_timeout: observed busy after %0d cycles expected idle", n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    drive_inputs();

    // Reset: three low cycles, then in_ready rises after release.
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Full mask, one frame.
    enq(8'hA5, 8'hFF);
    run_until_idle(60);

    // Sparse mask.
    enq(8'h0F, 8'h82);
    run_until_idle(60);

    // Empty mask.
    enq(8'h3C, 8'h00);
    run_until_idle(20);

    // Back-to-back single-channel frames.
    enq(8'h01, 8'h01);
    enq(8'h80, 8'h80);
    run_until_idle(40);

    // Back-to-back including an empty frame right after a busy one.
    enq(8'hFF, 8'h11);
    enq(8'h55, 8'h00);
    enq(8'hAA, 8'h40);
    run_until_idle(60);

    // Mid-frame reset during slot 3 of the fast instance.
    enq(8'($urandom), 8'hFF);
    n = 0;
    while (!(exp_q[0].size() > 0 && exp_q[0][0][4:2] == 3'd3) && n < 20) begin
      step();
      n++;
    end
    checks++;
    assert (n < 20)
    else begin
      errors++;
      $error("FAIL reach_slot3: observed %0d cycles expected under 20", n);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    enq(8'hF0, 8'h28);
    run_until_idle(60);

    // Random frames with random gaps on in_valid.
    gaps = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int u = 0; u < 2; u++)
        pend_q[u].push_back({8'($urandom),
                             ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom)});
    end
    drive_inputs();
    run_until_idle(2000);

    // Random frames offered back-to-back.
    gaps = 1'b0;
    for (int f = 0; f < 16; f++) begin
      for (int u = 0; u < 2; u++)
        pend_q[u].push_back({8'($urandom), 8'($urandom)});
    end
    drive_inputs();
    run_until_idle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
